// File: rtl/lzrw_fifo_pkg.sv
// Shared constants and width helpers for the byte-stream FIFO.
//   DEF_IN_BYTES / DEF_DEPTH / DEF_AFULL_MARGIN : default parameter values
//   ptr_width(n) : bits needed to address n entries (at least 1)
//   len_width(d) : bits for an occupancy count 0..d
//   cnt_width(b) : bits for a byte count 0..b
package lzrw_fifo_pkg;

    localparam int DEF_IN_BYTES     = 4;
    localparam int DEF_DEPTH        = 2048;
    localparam int DEF_AFULL_MARGIN = 8;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int len_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int cnt_width(input int in_bytes);
        return $clog2(in_bytes) + 1;
    endfunction

endpackage

// File: rtl/fifo_lane_ram.sv
// One byte lane of FIFO storage: ROWS x 8 bits.
//   clk   : clock
//   we    : write enable, waddr/wdata written on the rising edge
//   re    : read enable, mem[raddr] lands on rdata one cycle later
//   rdata : registered read data (holds when re is low)
module fifo_lane_ram
    import lzrw_fifo_pkg::*;
#(
    parameter int ROWS = DEF_DEPTH / DEF_IN_BYTES
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [ptr_width(ROWS)-1:0] waddr,
    input  logic [7:0]                 wdata,
    input  logic                       re,
    input  logic [ptr_width(ROWS)-1:0] raddr,
    output logic [7:0]                 rdata
);

    logic [7:0] mem [ROWS];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/byte_stream_fifo.sv
// Byte-granular FIFO: accepts words of 1..IN_BYTES bytes per cycle and
// emits one byte per cycle.
//   ClkxCI        : clock, rising edge
//   RstxRBI       : synchronous active-low reset
//   DInxDI        : write word, byte k at [8k+7:8k]
//   ByteCntxDI    : valid bytes in DInxDI (bytes 0..cnt-1)
//   WExSI         : write request
//   StopOutputxSI : consumer stall, blocks new reads
//   BusyxSO       : almost full (length >= DEPTH-AFULL_MARGIN)
//   OvfxSO        : sticky, set by any dropped write
//   DOutxDO       : output byte, valid with OutStrobexSO
//   OutStrobexSO  : output byte valid
//   LengthxDO     : bytes stored and not yet issued
module byte_stream_fifo
    import lzrw_fifo_pkg::*;
#(
    parameter int IN_BYTES     = DEF_IN_BYTES,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int AFULL_MARGIN = DEF_AFULL_MARGIN
) (
    input  logic                           ClkxCI,
    input  logic                           RstxRBI,
    input  logic [8*IN_BYTES-1:0]          DInxDI,
    input  logic [cnt_width(IN_BYTES)-1:0] ByteCntxDI,
    input  logic                           WExSI,
    input  logic                           StopOutputxSI,
    output logic                           BusyxSO,
    output logic                           OvfxSO,
    output logic [7:0]                     DOutxDO,
    output logic                           OutStrobexSO,
    output logic [len_width(DEPTH)-1:0]    LengthxDO
);

    localparam int ROWS   = DEPTH / IN_BYTES;
    localparam int PTR_W  = ptr_width(DEPTH);
    localparam int ROW_W  = ptr_width(ROWS);
    localparam int LANE_W = ptr_width(IN_BYTES);
    localparam int LEN_W  = len_width(DEPTH);
    localparam int CNT_W  = cnt_width(IN_BYTES);

    localparam logic [PTR_W:0]     LANES_P = (PTR_W + 1)'(IN_BYTES);
    localparam logic [LEN_W:0]     DEPTH_X = (LEN_W + 1)'(DEPTH);
    localparam logic [LEN_W-1:0]   BUSY_TH = LEN_W'(DEPTH - AFULL_MARGIN);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(IN_BYTES);

    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LANE_W-1:0] wr_lane, rd_lane, rd_lane_q;
    logic [ROW_W-1:0]  wr_row, rd_row;
    logic              cnt_ok, fits, accept, drop, issue;
    logic [LEN_W-1:0]  len_next;

    logic [IN_BYTES-1:0] lane_we;
    logic [LANE_W-1:0]   lane_rel   [IN_BYTES];
    logic [7:0]          lane_wdata [IN_BYTES];
    logic [ROW_W-1:0]    lane_waddr [IN_BYTES];
    logic [7:0]          lane_q     [IN_BYTES];

    // Byte address a lives in lane a mod IN_BYTES, row a / IN_BYTES.
    assign wr_lane = LANE_W'({1'b0, wr_ptr} % LANES_P);
    assign wr_row  = ROW_W'({1'b0, wr_ptr} / LANES_P);
    assign rd_lane = LANE_W'({1'b0, rd_ptr} % LANES_P);
    assign rd_row  = ROW_W'({1'b0, rd_ptr} / LANES_P);

    // Acceptance uses the registered length only; a read in the same cycle
    // does not make room for the write.
    assign cnt_ok   = (ByteCntxDI != '0) && (ByteCntxDI <= CNT_MAX);
    assign fits     = ({1'b0, LengthxDO} + (LEN_W + 1)'(ByteCntxDI)) <= DEPTH_X;
    assign accept   = WExSI && cnt_ok && fits;
    assign drop     = WExSI && !accept;
    assign issue    = (LengthxDO != '0) && !StopOutputxSI;
    assign len_next = LengthxDO
                    + (accept ? LEN_W'(ByteCntxDI) : LEN_W'(0))
                    - (issue  ? LEN_W'(1)          : LEN_W'(0));

    // Rotate the input word onto the lanes: lane l takes input byte
    // (l - start_lane) mod IN_BYTES; lanes before the start lane belong to
    // the following row.
    always_comb begin
        for (int l = 0; l < IN_BYTES; l++) begin
            lane_rel[l]   = LANE_W'(l) - wr_lane;
            lane_we[l]    = accept && (CNT_W'(lane_rel[l]) < ByteCntxDI);
            lane_wdata[l] = DInxDI[8*int'(lane_rel[l]) +: 8];
            lane_waddr[l] = (LANE_W'(l) < wr_lane) ? wr_row + ROW_W'(1) : wr_row;
        end
    end

    for (genvar g = 0; g < IN_BYTES; g++) begin : g_lane
        fifo_lane_ram #(
            .ROWS (ROWS)
        ) u_lane (
            .clk   (ClkxCI),
            .we    (lane_we[g]),
            .waddr (lane_waddr[g]),
            .wdata (lane_wdata[g]),
            .re    (issue),
            .raddr (rd_row),
            .rdata (lane_q[g])
        );
    end

    always_ff @(posedge ClkxCI) begin
        if (!RstxRBI) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            LengthxDO    <= '0;
            BusyxSO      <= 1'b0;
            OvfxSO       <= 1'b0;
            OutStrobexSO <= 1'b0;
            rd_lane_q    <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PTR_W'(ByteCntxDI);
            if (issue)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (drop)   OvfxSO <= 1'b1;
            LengthxDO    <= len_next;
            BusyxSO      <= (len_next >= BUSY_TH);
            OutStrobexSO <= issue;
            rd_lane_q    <= rd_lane;
        end
    end

    // The lane RAM output register is not reset, so the byte is gated by
    // the strobe to present zero after reset and between bytes.
    assign DOutxDO = OutStrobexSO ? lane_q[rd_lane_q] : 8'h00;

endmodule

// File: tb/tb_byte_stream_fifo.sv
// Directed self-checking bench for byte_stream_fifo at default parameters.
module tb_byte_stream_fifo;

    logic        clk = 1'b0;
    logic        rst_b;
    logic [31:0] din;
    logic [2:0]  cnt;
    logic        we;
    logic        stop;
    logic        busy;
    logic        ovf;
    logic [7:0]  dout;
    logic        strobe;
    logic [11:0] length;

    int checks   = 0;
    int failures = 0;
    logic [7:0] got_q[$];

    always #5 clk = ~clk;

    byte_stream_fifo dut (
        .ClkxCI        (clk),
        .RstxRBI       (rst_b),
        .DInxDI        (din),
        .ByteCntxDI    (cnt),
        .WExSI         (we),
        .StopOutputxSI (stop),
        .BusyxSO       (busy),
        .OvfxSO        (ovf),
        .DOutxDO       (dout),
        .OutStrobexSO  (strobe),
        .LengthxDO     (length)
    );

    always @(negedge clk) if (strobe) got_q.push_back(dout);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] inc_word(input int base);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'(base + k);
        return w;
    endfunction

    task automatic do_reset();
        rst_b = 1'b0;
        we    = 1'b0;
        stop  = 1'b0;
        step();
        rst_b = 1'b1;
        got_q.delete();
    endtask

    task automatic wait_empty(input string tag, input int max_cycles);
        int n = 0;
        while (!(length == 0 && strobe == 1'b0) && n < max_cycles) begin
            step();
            n++;
        end
        chk({tag, "_timeout"}, (n >= max_cycles) ? 1 : 0, 0);
    endtask

    // Received bytes must be the incrementing pattern 0,1,2,... mod 256.
    task automatic check_seq(input string tag, input int n);
        int errs = 0;
        chk({tag, "_count"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++)
            if (got_q[i] !== 8'(i)) errs++;
        chk({tag, "_order_errs"}, errs, 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp33 [4];
        logic [7:0] exp34 [5];
        int n, c, nw;
        exp33 = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp34 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};

        // Reset state
        rst_b = 1'b0; din = '0; cnt = '0; we = 1'b0; stop = 1'b0;
        step(); step();
        chk("rst_len", length, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_strobe", strobe, 0);
        chk("rst_dout", dout, 0);
        rst_b = 1'b1;

        // Single full word, exact cycle timing
        do_reset();
        din = 32'h44332211; cnt = 3'd4; we = 1'b1;
        step();
        we = 1'b0;
        chk("t33_len_c1", length, 4);
        chk("t33_strobe_c1", strobe, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("t33_strobe_c%0d", i + 2), strobe, 1);
            chk($sformatf("t33_dout_c%0d", i + 2), dout, exp33[i]);
            chk($sformatf("t33_len_c%0d", i + 2), length, 3 - i);
        end
        step();
        chk("t33_strobe_c6", strobe, 0);

        // Partial words while stalled
        do_reset();
        stop = 1'b1; we = 1'b1;
        din = 32'h00CCBBAA; cnt = 3'd3; step();
        din = 32'h0000EEDD; cnt = 3'd2; step();
        we = 1'b0;
        chk("t34_len", length, 5);
        chk("t34_no_strobe", strobe, 0);
        stop = 1'b0;
        n = 0;
        while (got_q.size() < 5 && n < 20) begin step(); n++; end
        chk("t34_count", got_q.size(), 5);
        for (int i = 0; i < 5 && i < got_q.size(); i++)
            chk($sformatf("t34_byte%0d", i), got_q[i], exp34[i]);

        // Invalid byte counts are dropped writes
        do_reset();
        we = 1'b1; cnt = 3'd0; din = 32'h12345678; step();
        we = 1'b0;
        chk("cnt0_ovf", ovf, 1);
        chk("cnt0_len", length, 0);
        do_reset();
        we = 1'b1; cnt = 3'd5; step();
        we = 1'b0;
        chk("cnt5_ovf", ovf, 1);
        chk("cnt5_len", length, 0);

        // Fill to almost-full and full, then overflow
        do_reset();
        stop = 1'b1; we = 1'b1; cnt = 3'd4;
        for (int i = 0; i < 509; i++) begin din = inc_word(4 * i); step(); end
        we = 1'b0;
        chk("t35_len_2036", length, 2036);
        chk("t35_busy_2036", busy, 0);
        we = 1'b1; din = inc_word(4 * 509); step();
        we = 1'b0;
        chk("t35_len_2040", length, 2040);
        chk("t35_busy_2040", busy, 1);
        we = 1'b1;
        for (int i = 510; i < 512; i++) begin din = inc_word(4 * i); step(); end
        we = 1'b0;
        chk("t35_len_full", length, 2048);
        chk("t35_ovf_full", ovf, 0);
        we = 1'b1; din = 32'hDEADBEEF; step();
        we = 1'b0;
        chk("t35_len_drop", length, 2048);
        chk("t35_ovf_drop", ovf, 1);
        // Full with concurrent read and write: write rejected, read issued
        we = 1'b1; cnt = 3'd1; stop = 1'b0; step();
        we = 1'b0;
        chk("t25_len", length, 2047);
        wait_empty("t35_drain", 3000);
        check_seq("t35", 2048);
        chk("t35_ovf_sticky", ovf, 1);

        // Long run with stall toggling and pointer wrap
        do_reset();
        c = 0; nw = 0;
        while (nw < 1000 && c < 20000) begin
            stop = ((c / 7) % 2) == 1;
            if (c % 4 == 0) begin
                we = 1'b1; cnt = 3'd3; din = inc_word(3 * nw); nw++;
            end else begin
                we = 1'b0;
            end
            step();
            c++;
        end
        we = 1'b0; stop = 1'b0;
        wait_empty("t36_drain", 5000);
        check_seq("t36", 3000);
        chk("t36_ovf", ovf, 0);

        // Near-full write with concurrent read is still dropped
        do_reset();
        stop = 1'b1; we = 1'b1; cnt = 3'd4;
        for (int i = 0; i < 511; i++) begin din = inc_word(4 * i); step(); end
        cnt = 3'd1; din = inc_word(2044); step();
        we = 1'b0;
        chk("t37_len_2045", length, 2045);
        we = 1'b1; cnt = 3'd4; stop = 1'b0; step();
        we = 1'b0; stop = 1'b1;
        chk("t37_len_2044", length, 2044);
        chk("t37_ovf", ovf, 1);

        // Reset with a byte in flight
        do_reset();
        stop = 1'b1; we = 1'b1; cnt = 3'd4;
        for (int i = 0; i < 25; i++) begin din = inc_word(4 * i); step(); end
        we = 1'b0;
        chk("t38_len_100", length, 100);
        stop = 1'b0; step();
        chk("t38_strobe_live", strobe, 1);
        rst_b = 1'b0; step();
        chk("t38_len", length, 0);
        chk("t38_busy", busy, 0);
        chk("t38_ovf", ovf, 0);
        chk("t38_strobe", strobe, 0);
        chk("t38_dout", dout, 0);
        rst_b = 1'b1;
        got_q.delete();
        repeat (10) step();
        chk("t38_no_strobes", got_q.size(), 0);
        chk("t38_len_after", length, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
